shift_reg_ctrl: RTL and testbench
=================================

// Module: shift_reg_ctrl
// PURPOSE
//  Command sequencer for the 4-to-1-mux / D-flop shift register datapath.
//  - Accepts one command per start pulse: hold, shift right, shift left or parallel load.
//  - Drives the per-bit mux select for a programmed number of cycles, then reports done.
//  - Owns the register bits through one sub-module, so q is visible at the block boundary.
// PARAMETERS
//  WIDTH  4  register width in bits (>=2)
//  CNT_W  3  width of shift-count field; max shifts per command = 2**CNT_W-1
// PORTS
//  clk      in   1      system clock, rising edge
//  rst      in   1      reset: asynchronous, active-high
//  start    in   1      command strobe, sampled only in IDLE
//  op       in   2      00 hold, 01 shift right, 10 shift left, 11 load
//  count    in   CNT_W  number of shift cycles (ignored for load/hold)
//  din      in   WIDTH  parallel load data
//  ser_in   in   1      serial fill bit for shifts
//  sel      out  2      mux select to datapath (00 hold, 01 shr, 10 shl, 11 load)
//  q        out  WIDTH  register contents
//  busy     out  1      high in LOAD/SHIFT/DONE
//  done     out  1      one-cycle pulse on command completion
// BEHAVIOUR
//  - Reset (async, any time) forces:
//    - state=IDLE, q=0, sel=00, busy=0, done=0, internal counter=0.
//  - FSM states: IDLE, LOAD, SHIFT, DONE.
//  - IDLE, start=1 at edge k:
//    - latch op, count and din.
//    - op=11 goes to LOAD.
//    - op=01/10 with count!=0 goes to SHIFT.
//    - otherwise (hold, or count=0) goes to DONE.
//  - LOAD: sel=11 for one cycle; q<=din_latched at edge k+1; next state DONE.
//  - SHIFT: sel=op_latched for exactly N=count cycles (edges k+1..k+N).
//    - shr: q <= {ser_in, q[WIDTH-1:1]}.
//    - shl: q <= {q[WIDTH-2:0], ser_in}.
//    - counter decrements each edge; when it reaches 1, next state DONE.
//  - DONE: done=1, sel=00 for one cycle; then back to IDLE.
//  - sel is decoded combinationally from state and latched op.
//  - sel=00 in IDLE/DONE; q holds.
//  - Latency: start to done = N+1 cycles for shifts, 2 for load, 1 for hold/count=0.
//  - start outside IDLE (including DONE) is ignored; no queueing.
//    - Earliest new start is the first IDLE cycle after done.
//  - din/count changes after acceptance have no effect; ser_in is used live each shift cycle.
//  - Reset mid-command aborts immediately; no done pulse is produced.
// CONFIGURATION
//  SHREG_ROTATE_EN defined:
//    - adds input port rotate (1 bit), latched with the command.
//    - rotate=1 feeds the bit shifted out back in: shr fill = q[0], shl fill = q[WIDTH-1].
//    - ser_in is ignored for that command.
//  SHREG_ROTATE_EN undefined:
//    - no rotate port; fill bit is always ser_in.
// STRUCTURE
//  - Package shreg_pkg holds:
//    - 2-bit op/sel encodings: OP_HOLD, OP_SHR, OP_SHL, OP_LOAD.
//    - FSM state encodings: S_IDLE, S_LOAD, S_SHIFT, S_DONE.
//  - Sub-module shreg_core(WIDTH): per-bit 4-to-1 mux plus async-reset D flop.
//    - Ports: clk, rst, sel, din, fill, q.
//    - Controller contains FSM, counter and command latches only.
// TESTING (WIDTH=4, CNT_W=3)
//  - Load: start, op=11, din=1011.
//    -> q=1011 one edge later; done pulses the next cycle; busy falls with it.
//  - Shift right: from q=1011, op=01, count=2, ser_in=0.
//    -> q=0101 then 0010; sel=01 for exactly 2 cycles; done on cycle 3.
//  - Shift left: from q=1011, op=10, count=1, ser_in=1.
//    -> q=0111; count=0 instead -> done next cycle, q stays 1011.
//  - Busy: start asserted every cycle during a count=5 shift.
//    -> only the first start is accepted; exactly 5 shifts, one done.
//  - Reset: rst pulsed during cycle 2 of a count=4 shift.
//    -> q=0000, sel=00, busy=0 asynchronously; no done pulse.
//  - Rotate (SHREG_ROTATE_EN defined): q=1011, op=01, count=1, rotate=1.
//    -> q=1101; rotate=0 with ser_in=0 -> q=0101.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared encodings for the shift register sequencer: op/sel codes and controller FSM states.
package shreg_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_SHR  = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_SHIFT = 2'b10,
        S_DONE  = 2'b11
    } state_t;

endpackage

// File: rtl/shreg_core.sv
// Shift register datapath: per-bit 4-to-1 mux (hold/shr/shl/load) feeding an async-reset D flop.
module shreg_core
    import shreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] din,
    input  logic             fill,
    output logic [WIDTH-1:0] q
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic right_src;
            logic left_src;
            logic bit_d;
            logic bit_q;

            // End bits take the fill bit instead of a neighbour.
            if (gi == WIDTH - 1) begin : g_msb
                assign right_src = fill;
            end else begin : g_mid_r
                assign right_src = q[gi+1];
            end

            if (gi == 0) begin : g_lsb
                assign left_src = fill;
            end else begin : g_mid_l
                assign left_src = q[gi-1];
            end

            always_comb begin
                bit_d = bit_q;
                case (sel)
                    OP_SHR:  bit_d = right_src;
                    OP_SHL:  bit_d = left_src;
                    OP_LOAD: bit_d = din[gi];
                    default: bit_d = bit_q;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) bit_q <= 1'b0;
                else     bit_q <= bit_d;
            end

            assign q[gi] = bit_q;
        end
    endgenerate

endmodule

// File: rtl/shift_reg_ctrl.sv
// Command sequencer for the shift register datapath: hold, shift right/left N times, or load.
// Optional macro SHREG_ROTATE_EN adds a rotate input that recirculates the shifted-out bit.
module shift_reg_ctrl
    import shreg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_in,
`ifdef SHREG_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic             fill;

`ifdef SHREG_ROTATE_EN
    logic rot_q, rot_d;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
`ifdef SHREG_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = count;
                    din_d = din;
`ifdef SHREG_ROTATE_EN
                    rot_d = rotate;
`endif
                    if (op == OP_LOAD)
                        state_d = S_LOAD;
                    else if ((op == OP_SHR || op == OP_SHL) && count != '0)
                        state_d = S_SHIFT;
                    else
                        state_d = S_DONE;
                end
            end
            S_LOAD:  state_d = S_DONE;
            S_SHIFT: begin
                // The edge that consumes the last programmed shift also leaves SHIFT.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1))
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            din_q   <= '0;
`ifdef SHREG_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
`ifdef SHREG_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    always_comb begin
        case (state_q)
            S_LOAD:  sel = OP_LOAD;
            S_SHIFT: sel = op_q;
            default: sel = OP_HOLD;
        endcase
    end

`ifdef SHREG_ROTATE_EN
    assign fill = rot_q ? ((op_q == OP_SHR) ? q[0] : q[WIDTH-1]) : ser_in;
`else
    assign fill = ser_in;
`endif

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    shreg_core #(.WIDTH(WIDTH)) u_core (
        .clk  (clk),
        .rst  (rst),
        .sel  (sel),
        .din  (din_q),
        .fill (fill),
        .q    (q)
    );

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench for shift_reg_ctrl: driver pushes model results, monitor checks on each done pulse.
module tb_shift_reg_ctrl;

    localparam int W  = 4;
    localparam int CW = 3;
`ifdef SHREG_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [CW-1:0] count;
    logic [W-1:0]  din;
    logic          ser_in;
`ifdef SHREG_ROTATE_EN
    logic          rotate;
`endif
    logic [1:0]    sel;
    logic [W-1:0]  q;
    logic          busy;
    logic          done;

    shift_reg_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .count  (count),
        .din    (din),
        .ser_in (ser_in),
`ifdef SHREG_ROTATE_EN
        .rotate (rotate),
`endif
        .sel    (sel),
        .q      (q),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        int           lat;
        int           sel_cycles;
        logic [1:0]   sel_val;
        int           start_c;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_q = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts active-select cycles and checks each completed command.
    int   sel_seen = 0;
    logic sel_bad  = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sel_seen = 0;
                sel_bad  = 1'b0;
            end else begin
                if (sel != 2'b00) begin
                    sel_seen++;
                    if (sb.size() == 0 || sel !== sb[0].sel_val) sel_bad = 1'b1;
                end
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", 32'(done), 32'd0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("q_at_done", 32'(q), 32'(e.q));
                        check("latency", 32'(cyc - e.start_c), 32'(e.lat));
                        check("sel_cycles", 32'(sel_seen), 32'(e.sel_cycles));
                        check("sel_value", 32'(sel_bad), 32'd0);
                        $display("cmd done: q=%b latency=%0d sel_cycles=%0d", q, cyc - e.start_c, sel_seen);
                    end
                    sel_seen = 0;
                    sel_bad  = 1'b0;
                end
            end
        end
    end

    // Issue one command, push its expected outcome, and drive ser_in from bits[] during shifts.
    task automatic run_cmd(input logic [1:0] o, input int n, input logic [W-1:0] d,
                           input logic rot, input logic [7:0] bits, input bit hold_start);
        exp_t         e;
        logic [W-1:0] m;
        logic         f;
        bit           finished;
        m = model_q;
        if (o == 2'b11) begin
            m = d; e.lat = 2; e.sel_cycles = 1; e.sel_val = 2'b11;
        end else if ((o == 2'b01 || o == 2'b10) && n != 0) begin
            for (int i = 0; i < n; i++) begin
                if (rot && ROT_EN) f = (o == 2'b01) ? m[0] : m[W-1];
                else               f = bits[i];
                if (o == 2'b01) m = (m >> 1) | (W'(f) << (W - 1));
                else            m = (m << 1) | W'(f);
            end
            e.lat = n + 1; e.sel_cycles = n; e.sel_val = o;
        end else begin
            e.lat = 1; e.sel_cycles = 0; e.sel_val = 2'b00;
        end
        e.q = m;
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        count  = n[CW-1:0];
        din    = d;
        ser_in = 1'($urandom);
`ifdef SHREG_ROTATE_EN
        rotate = rot;
`endif
        e.start_c = cyc;
        sb.push_back(e);
        model_q = m;
        finished = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                start    = 1'b0;
                finished = 1'b1;
                break;
            end
            start  = hold_start;
            op     = 2'($urandom);
            count  = CW'($urandom);
            din    = W'($urandom);
            ser_in = bits[i % 8];
`ifdef SHREG_ROTATE_EN
            rotate = 1'($urandom);
`endif
        end
        if (!finished) begin
            check("done_timeout", 32'd0, 32'd1);
            sb.delete();
            start = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; count = '0; din = '0; ser_in = 1'b0;
`ifdef SHREG_ROTATE_EN
        rotate = 1'b0;
`endif
        #12;
        check("rst_q", 32'(q), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        run_cmd(2'b11, 0, 4'b1011, 1'b0, 8'h00, 1'b0);
        check("load_q", 32'(q), 32'b1011);
        run_cmd(2'b01, 2, 4'b0000, 1'b0, 8'h00, 1'b0);
        check("shr2_q", 32'(q), 32'b0010);
        run_cmd(2'b11, 0, 4'b1011, 1'b0, 8'h00, 1'b0);
        run_cmd(2'b10, 1, 4'b0000, 1'b0, 8'hFF, 1'b0);
        check("shl1_q", 32'(q), 32'b0111);
        run_cmd(2'b11, 0, 4'b1011, 1'b0, 8'h00, 1'b0);
        run_cmd(2'b10, 0, 4'b0000, 1'b0, 8'hFF, 1'b0);
        check("shl0_q", 32'(q), 32'b1011);
        run_cmd(2'b00, 5, 4'b0110, 1'b0, 8'hFF, 1'b0);
        check("hold_q", 32'(q), 32'b1011);
        run_cmd(2'b01, 5, 4'b0000, 1'b0, 8'($urandom), 1'b1);

        if (ROT_EN) begin
            run_cmd(2'b11, 0, 4'b1011, 1'b0, 8'h00, 1'b0);
            run_cmd(2'b01, 1, 4'b0000, 1'b1, 8'h00, 1'b0);
            check("rot_shr_q", 32'(q), 32'b1101);
            run_cmd(2'b11, 0, 4'b1011, 1'b0, 8'h00, 1'b0);
            run_cmd(2'b01, 1, 4'b0000, 1'b0, 8'h00, 1'b0);
            check("norot_shr_q", 32'(q), 32'b0101);
        end

        // Reset during the second cycle of a count=4 shift: no expectation is pushed.
        @(negedge clk);
        start = 1'b1; op = 2'b01; count = 3'd4; din = '0; ser_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_q", 32'(q), 32'd0);
        check("midrst_sel", 32'(sel), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        model_q = '0;
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("postrst_busy", 32'(busy), 32'd0);

        for (int k = 0; k < 40; k++) begin
            run_cmd(2'($urandom), int'($urandom_range(0, 7)), W'($urandom),
                    1'($urandom), 8'($urandom), 1'($urandom));
        end

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
